// File: rtl/keypad_if.sv
// keypad_if: keypad pins plus the key-code hand-off to the consumer.
//   master: the scanner. It reads rows_n and key_ack and drives cols_n, key_code,
//           key_valid, key_down and overrun.
//   slave : the keypad/consumer side, with the directions mirrored.
//   rows_n    : keypad rows, active-low, asynchronous to clk
//   cols_n    : keypad columns, active-low, at most one column low at a time
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : high while an accepted key has not been acknowledged
//   key_ack   : consumer acknowledge, clears key_valid
//   key_down  : high while a debounced key is held
//   overrun   : sticky, set when a key is accepted over an unacknowledged one
interface keypad_if;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_down;
  logic       overrun;

  modport master (
    input  rows_n, key_ack,
    output cols_n, key_code, key_valid, key_down, overrun
  );

  modport slave (
    output rows_n, key_ack,
    input  cols_n, key_code, key_valid, key_down, overrun
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner.
//   Drives one column low at a time and reads the active-low rows. A prescaler
//   sets how long each column stays low. Each full four-column scan is
//   classified as NONE, SINGLE or MULTI. A debounce FSM accepts a key after
//   DEBOUNCE_SCANS identical SINGLE scans. It treats the key as released after
//   DEBOUNCE_SCANS NONE scans. Accepted codes are presented through a
//   valid/ack holding register.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous, active-high
//   turbosim : selects PRESCALER_RLD_TURBOSIM as the column dwell reload
//   en       : scanner enable. When low, the scan state is reinitialised. The
//              held key code, valid flag and overrun flag are kept, and the
//              acknowledge still works.
//   kp       : keypad_if.master (rows_n, key_ack in; cols_n, key_code,
//              key_valid, key_down, overrun out)
// Build option:
//   KEYPAD_REPEAT_EN : auto-repeat of a held key. The first repeat comes
//                      REPEAT_DELAY_SCANS scans after acceptance, and further
//                      repeats follow every REPEAT_RATE_SCANS scans.
module keypad_scan #(
  parameter int unsigned PRESCALER_RLD          = 49_999,
  parameter int unsigned PRESCALER_RLD_TURBOSIM = 7,
  parameter int unsigned DEBOUNCE_SCANS         = 3,
  parameter int unsigned REPEAT_DELAY_SCANS     = 100,
  parameter int unsigned REPEAT_RATE_SCANS      = 25
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     turbosim,
  input  logic     en,
  keypad_if.master kp
);

  localparam int unsigned PRESC_MAX = (PRESCALER_RLD > PRESCALER_RLD_TURBOSIM) ?
                                      PRESCALER_RLD : PRESCALER_RLD_TURBOSIM;
  localparam int PRESC_W = $clog2(PRESC_MAX + 1);
  // The debounce counter holds "scans still required minus one". IDLE/HELD has
  // already consumed the first qualifying scan when the counter is loaded.
  localparam int unsigned CNT_LOAD = (DEBOUNCE_SCANS >= 2) ? DEBOUNCE_SCANS - 2 : 0;
  localparam int CNT_W = (CNT_LOAD > 0) ? $clog2(CNT_LOAD + 1) : 1;

  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD, ST_RELEASE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [3:0]         cand_q;
  logic [3:0]         rows_s1_q, rows_s2_q;
  logic [PRESC_W-1:0] presc_q;
  logic [1:0]         ptr_q;
  logic [1:0]         acc_cnt_q;
  logic [3:0]         acc_code_q;
  logic [3:0]         key_code_q;
  logic               key_valid_q, key_down_q, overrun_q;

  logic [PRESC_W-1:0] presc_rld;
  logic               scan_en, tick, scan_end;
  logic [3:0]         low;
  logic [1:0]         row_idx;
  logic               one_low;
  logic [1:0]         samp_cnt;
  logic [3:0]         samp_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY_SCANS > REPEAT_RATE_SCANS) ?
                                    REPEAT_DELAY_SCANS : REPEAT_RATE_SCANS;
  localparam int REP_W = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LD = REP_W'(REPEAT_DELAY_SCANS - 1);
  localparam logic [REP_W-1:0] REP_RATE_LD  = REP_W'(REPEAT_RATE_SCANS - 1);
  logic [REP_W-1:0] rep_q;
`else
  // The repeat parameters are inert without the feature.
  if (REPEAT_DELAY_SCANS == 0 || REPEAT_RATE_SCANS == 0) begin : g_repeat_cfg_unused
  end
`endif

  assign presc_rld = turbosim ? PRESC_W'(PRESCALER_RLD_TURBOSIM) : PRESC_W'(PRESCALER_RLD);
  assign scan_en   = en & ~reset;
  assign tick      = (presc_q == '0);
  assign scan_end  = tick & (ptr_q == 2'd3);

  assign kp.cols_n    = scan_en ? ~(4'b0001 << ptr_q) : 4'b1111;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
  assign kp.overrun   = overrun_q;

  // Fold the current column's sample into the scan accumulator. The result
  // includes this sample, so the scan-end decision sees the last column too.
  always_comb begin
    low       = ~rows_s2_q;
    row_idx   = 2'd0;
    one_low   = 1'b1;
    samp_cnt  = acc_cnt_q;
    samp_code = acc_code_q;
    case (low)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
    if (one_low) begin
      samp_cnt  = (acc_cnt_q == RES_MULTI) ? RES_MULTI : acc_cnt_q + 2'd1;
      samp_code = {row_idx, ptr_q};
    end else if (low != 4'b0000) begin
      samp_cnt = RES_MULTI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_s1_q   <= 4'b1111;
      rows_s2_q   <= 4'b1111;
      presc_q     <= presc_rld;
      ptr_q       <= 2'd0;
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      rows_s1_q <= kp.rows_n;
      rows_s2_q <= rows_s1_q;

      // The acknowledge is handled first. An accept later in this block
      // overrides key_valid, which gives "new code, still valid, no overrun"
      // when accept and ack land together.
      if (kp.key_ack && key_valid_q) begin
        key_valid_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      if (!en) begin
        presc_q    <= presc_rld;
        ptr_q      <= 2'd0;
        acc_cnt_q  <= 2'd0;
        acc_code_q <= 4'd0;
        state_q    <= ST_IDLE;
        cnt_q      <= '0;
        key_down_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_q      <= '0;
`endif
      end else begin
        if (tick) begin
          presc_q <= presc_rld;
          ptr_q   <= ptr_q + 2'd1;
          if (scan_end) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
          end else begin
            acc_cnt_q  <= samp_cnt;
            acc_code_q <= samp_code;
          end
        end else begin
          presc_q <= presc_q - PRESC_W'(1);
        end

        if (scan_end) begin
          case (state_q)
            ST_IDLE: begin
              if (samp_cnt == RES_SINGLE) begin
                cand_q <= samp_code;
                if (DEBOUNCE_SCANS <= 1) begin
                  key_code_q  <= samp_code;
                  key_valid_q <= 1'b1;
                  if (key_valid_q && !kp.key_ack) overrun_q <= 1'b1;
                  state_q     <= ST_HELD;
                  key_down_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rep_q       <= REP_DELAY_LD;
`endif
                end else begin
                  state_q <= ST_PRESS;
                  cnt_q   <= CNT_W'(CNT_LOAD);
                end
              end
            end
            ST_PRESS: begin
              if (samp_cnt == RES_SINGLE && samp_code == cand_q) begin
                if (cnt_q == '0) begin
                  key_code_q  <= cand_q;
                  key_valid_q <= 1'b1;
                  if (key_valid_q && !kp.key_ack) overrun_q <= 1'b1;
                  state_q     <= ST_HELD;
                  key_down_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                  rep_q       <= REP_DELAY_LD;
`endif
                end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                end
              end else begin
                state_q <= ST_IDLE;
              end
            end
            ST_HELD: begin
              if (samp_cnt == RES_NONE) begin
`ifdef KEYPAD_REPEAT_EN
                rep_q <= '0;
`endif
                if (DEBOUNCE_SCANS <= 1) begin
                  state_q    <= ST_IDLE;
                  key_down_q <= 1'b0;
                end else begin
                  state_q <= ST_RELEASE;
                  cnt_q   <= CNT_W'(CNT_LOAD);
                end
              end
`ifdef KEYPAD_REPEAT_EN
              else if (rep_q == '0) begin
                key_code_q  <= cand_q;
                key_valid_q <= 1'b1;
                if (key_valid_q && !kp.key_ack) overrun_q <= 1'b1;
                rep_q       <= REP_RATE_LD;
              end else begin
                rep_q <= rep_q - REP_W'(1);
              end
`endif
            end
            ST_RELEASE: begin
              if (samp_cnt == RES_NONE) begin
                if (cnt_q == '0) begin
                  state_q    <= ST_IDLE;
                  key_down_q <= 1'b0;
                end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
                end
              end else begin
                // The key bounced back before release was confirmed. Resume
                // holding without a second accept.
                state_q <= ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                rep_q   <= REP_DELAY_LD;
`endif
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed test of keypad_scan with turbosim=1 and
// DEBOUNCE_SCANS=3, giving an 8-cycle column dwell and a 32-cycle scan. A
// keypad model pulls row r low whenever key r*4+c is pressed and column c is
// driven low. Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_keypad_scan;
  logic        clk = 1'b0;
  logic        reset, turbosim, en;
  logic [15:0] keys;
  int          n_cmp = 0;
  int          n_fail = 0;

  keypad_if kp ();

  keypad_scan #(
    .PRESCALER_RLD(49_999), .PRESCALER_RLD_TURBOSIM(7), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY_SCANS(4), .REPEAT_RATE_SCANS(2)
  ) dut (
    .clk(clk), .reset(reset), .turbosim(turbosim), .en(en), .kp(kp.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp.rows_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.cols_n[c]) kp.rows_n[r] = 1'b0;
  end

  // Returns 1 ns after the edge on which column 3 wraps back to column 0,
  // which is the scan-end edge.
  task automatic wait_scan_end();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = kp.cols_n;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (kp.cols_n == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = kp.cols_n;
    end
    if (!found) begin
      n_cmp++; n_fail++;
      $display("FAIL scan_wait: no scan end within 40 cycles, cols_n=%b", kp.cols_n);
    end
  endtask

  task automatic run_scans(input int n);
    for (int i = 0; i < n; i++) wait_scan_end();
  endtask

  task automatic ack_pulse();
    kp.key_ack = 1'b1;
    @(posedge clk); #1;
    kp.key_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    reset = 1'b1; en = 1'b0; turbosim = 1'b1; keys = 16'h0; kp.key_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (kp.cols_n !== 4'b1111) begin n_fail++; $display("FAIL reset_cols: got %b want 1111", kp.cols_n); end
    n_cmp++;
    if ({kp.key_code, kp.key_valid, kp.key_down, kp.overrun} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got code=%h v=%b d=%b o=%b want all 0",
               kp.key_code, kp.key_valid, kp.key_down, kp.overrun);
    end
    reset = 1'b0; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      exp = ~(4'b0001 << (i / 8));
      n_cmp++;
      if (kp.cols_n !== exp) begin n_fail++; $display("FAIL scan_order[%0d]: got %b want %b", i, kp.cols_n, exp); end
    end
    n_cmp++;
    if ({kp.key_valid, kp.key_down, kp.overrun} !== 3'b0) begin
      n_fail++; $display("FAIL idle_outs: got v=%b d=%b o=%b want 000", kp.key_valid, kp.key_down, kp.overrun);
    end
  endtask

  task automatic test_single_press();
    wait_scan_end();
    keys = 16'h0040;
    run_scans(2);
    n_cmp++;
    if ({kp.key_valid, kp.key_down} !== 2'b00) begin
      n_fail++; $display("FAIL press_early: got v=%b d=%b want 00 after 2 scans", kp.key_valid, kp.key_down);
    end
    run_scans(1);
    n_cmp++;
    if ({kp.key_valid, kp.key_code, kp.key_down} !== {1'b1, 4'h6, 1'b1}) begin
      n_fail++; $display("FAIL press_accept: got v=%b code=%h d=%b want v=1 code=6 d=1",
                         kp.key_valid, kp.key_code, kp.key_down);
    end
    run_scans(2);
    n_cmp++;
    if (kp.key_valid !== 1'b1) begin n_fail++; $display("FAIL press_hold_valid: got %b want 1", kp.key_valid); end
    ack_pulse();
    n_cmp++;
    if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL press_ack: got %b want 0", kp.key_valid); end
    wait_scan_end();
    keys = 16'h0;
    run_scans(2);
    n_cmp++;
    if (kp.key_down !== 1'b1) begin n_fail++; $display("FAIL release_early: got %b want 1", kp.key_down); end
    run_scans(1);
    n_cmp++;
    if ({kp.key_down, kp.key_valid} !== 2'b00) begin
      n_fail++; $display("FAIL release_done: got d=%b v=%b want 00", kp.key_down, kp.key_valid);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      keys = 16'h0040;
      run_scans(1);
      keys = 16'h0;
      run_scans(1);
      n_cmp++;
      if ({kp.key_valid, kp.key_down} !== 2'b00) begin
        n_fail++; $display("FAIL bounce[%0d]: got v=%b d=%b want 00", i, kp.key_valid, kp.key_down);
      end
    end
  endtask

  task automatic test_multi_key();
    keys = 16'h0042;
    for (int i = 0; i < 5; i++) begin
      run_scans(1);
      n_cmp++;
      if ({kp.key_valid, kp.key_down} !== 2'b00) begin
        n_fail++; $display("FAIL multi[%0d]: got v=%b d=%b want 00", i, kp.key_valid, kp.key_down);
      end
    end
    keys = 16'h0;
    run_scans(1);
  endtask

  task automatic test_overrun();
    keys = 16'h0040;
    run_scans(3);
    n_cmp++;
    if ({kp.key_valid, kp.key_code, kp.overrun} !== {1'b1, 4'h6, 1'b0}) begin
      n_fail++; $display("FAIL ovr_first: got v=%b code=%h o=%b want v=1 code=6 o=0",
                         kp.key_valid, kp.key_code, kp.overrun);
    end
    keys = 16'h0;
    run_scans(3);
    keys = 16'h0200;
    run_scans(3);
    n_cmp++;
    if ({kp.key_valid, kp.key_code, kp.overrun} !== {1'b1, 4'h9, 1'b1}) begin
      n_fail++; $display("FAIL ovr_second: got v=%b code=%h o=%b want v=1 code=9 o=1",
                         kp.key_valid, kp.key_code, kp.overrun);
    end
    keys = 16'h0;
    run_scans(3);
  endtask

  task automatic test_ack_collision();
    keys = 16'h0040;
    run_scans(2);
    repeat (31) @(posedge clk);
    #1;
    n_cmp++;
    if ({kp.key_valid, kp.key_code, kp.overrun} !== {1'b1, 4'h9, 1'b1}) begin
      n_fail++; $display("FAIL coll_before: got v=%b code=%h o=%b want v=1 code=9 o=1",
                         kp.key_valid, kp.key_code, kp.overrun);
    end
    ack_pulse();
    n_cmp++;
    if ({kp.key_valid, kp.key_code, kp.overrun} !== {1'b1, 4'h6, 1'b0}) begin
      n_fail++; $display("FAIL coll_after: got v=%b code=%h o=%b want v=1 code=6 o=0",
                         kp.key_valid, kp.key_code, kp.overrun);
    end
    ack_pulse();
    n_cmp++;
    if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL coll_ack: got %b want 0", kp.key_valid); end
    keys = 16'h0;
    run_scans(3);
  endtask

  task automatic test_disable();
    keys = 16'h0040;
    run_scans(3);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({kp.cols_n, kp.key_down, kp.key_valid, kp.key_code} !== {4'b1111, 1'b0, 1'b1, 4'h6}) begin
      n_fail++; $display("FAIL disable: got cols=%b d=%b v=%b code=%h want cols=1111 d=0 v=1 code=6",
                         kp.cols_n, kp.key_down, kp.key_valid, kp.key_code);
    end
    ack_pulse();
    n_cmp++;
    if (kp.key_valid !== 1'b0) begin n_fail++; $display("FAIL disable_ack: got %b want 0", kp.key_valid); end
    keys = 16'h0;
    en = 1'b1;
    run_scans(1);
    n_cmp++;
    if ({kp.key_down, kp.key_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reenable: got d=%b v=%b want 00", kp.key_down, kp.key_valid);
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  task automatic test_repeat();
    bit exp;
    wait_scan_end();
    keys = 16'h0040;
    for (int s = 1; s <= 15; s++) begin
      run_scans(1);
      exp = (s == 3 || s == 7 || s == 9 || s == 11 || s == 13 || s == 15);
      n_cmp++;
      if (kp.key_valid !== exp) begin
        n_fail++; $display("FAIL repeat[scan %0d]: got v=%b want %b", s, kp.key_valid, exp);
      end
      if (kp.key_valid === 1'b1) ack_pulse();
    end
    n_cmp++;
    if (kp.overrun !== 1'b0) begin n_fail++; $display("FAIL repeat_ovr: got %b want 0", kp.overrun); end
    keys = 16'h0;
    run_scans(3);
  endtask
`else
  task automatic test_no_repeat();
    wait_scan_end();
    keys = 16'h0040;
    run_scans(3);
    n_cmp++;
    if (kp.key_valid !== 1'b1) begin n_fail++; $display("FAIL norep_accept: got %b want 1", kp.key_valid); end
    ack_pulse();
    for (int s = 0; s < 8; s++) begin
      run_scans(1);
      n_cmp++;
      if ({kp.key_valid, kp.key_down} !== 2'b01) begin
        n_fail++; $display("FAIL norep_hold[%0d]: got v=%b d=%b want v=0 d=1", s, kp.key_valid, kp.key_down);
      end
    end
    keys = 16'h0;
    run_scans(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_overrun();
    test_ack_collision();
    test_disable();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`else
    test_no_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
